// File: rtl/disp_pkg.sv
// Shared codes, segment decoding and the converter state type for the multiplexed numeric display.
package disp_pkg;

  localparam logic [3:0] DIG_MINUS = 4'd10;
  localparam logic [3:0] DIG_BLANK = 4'd11;

  typedef logic [6:0] seg_t;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_LOAD} state_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  function automatic seg_t seg_of(input logic [3:0] code);
    case (code)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      4'd10:   seg_of = 7'b0111111;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one shift-add-3 step per clock, result held in S_LOAD for one cycle.
module bin2bcd_seq
  import disp_pkg::*;
#(
  parameter int W     = 8,
  parameter int N_DIG = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [W-1:0]       bin,
  output logic               busy,
  output logic               done,
  output logic [4*N_DIG-1:0] bcd
);

  localparam int CW = $clog2(W + 1);

  state_t             state, state_next;
  logic [W-1:0]       bin_reg;
  logic [4*N_DIG-1:0] bcd_reg;
  logic [4*N_DIG-1:0] bcd_adj;
  logic [CW-1:0]      iter_reg;
  logic               last_iter;

  genvar gi;
  generate
    for (gi = 0; gi < N_DIG; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end
  endgenerate

  assign last_iter = (iter_reg == CW'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_CONV;
      S_CONV:  if (last_iter) state_next = S_LOAD;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_reg  <= '0;
      bcd_reg  <= '0;
      iter_reg <= '0;
    end else if (state == S_IDLE && start) begin
      bin_reg  <= bin;
      bcd_reg  <= '0;
      iter_reg <= '0;
    end else if (state == S_CONV) begin
      {bcd_reg, bin_reg} <= {bcd_adj[4*N_DIG-2:0], bin_reg, 1'b0};
      iter_reg           <= iter_reg + CW'(1);
    end
  end

  assign bcd = bcd_reg;

endmodule

// File: rtl/display_num_mux.sv
// N-digit multiplexed 7-segment driver: sign/magnitude capture, BCD formatting into
// a display buffer, and a refresh divider that scans one digit per tick.
module display_num_mux
  import disp_pkg::*;
#(
  parameter int W     = 8,
  parameter int N_DIG = 4,
  parameter int DIV   = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [W-1:0]     value,
  input  logic             signed_mode,
  input  logic             blank_lz,
  output logic             busy,
  output logic             done,
  output logic [6:0]       SSeg,
  output logic [N_DIG-1:0] an
);

  localparam int IW   = $clog2(N_DIG);
  localparam int CNTW = $clog2(DIV);

  generate
    if (pow10(N_DIG - 1) < (64'd1 << W)) begin : g_bad_ndig
      $error("display_num_mux: N_DIG too small for W");
    end
  endgenerate

  logic               accept, neg_in, conv_busy, conv_done;
  logic [W-1:0]       mag_in;
  logic [4*N_DIG-1:0] conv_bcd;
  logic               neg_reg, blank_reg, done_reg;
  logic [3:0]         disp_buf [N_DIG];
  logic [3:0]         fmt [N_DIG];
  logic [IW-1:0]      msd;
  logic               show_minus;
  int                 minus_pos;
  logic [CNTW-1:0]    cnt_reg;
  logic [IW-1:0]      idx_reg;
  logic               tick;
  logic [N_DIG-1:0]   an_reg;
  seg_t               seg_reg;

  assign accept = valid && !conv_busy;
  assign neg_in = signed_mode && value[W-1];
  // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude
  assign mag_in = neg_in ? (~value + W'(1)) : value;

  bin2bcd_seq #(.W(W), .N_DIG(N_DIG)) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept),
    .bin   (mag_in),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_reg   <= 1'b0;
      blank_reg <= 1'b0;
    end else if (accept) begin
      neg_reg   <= neg_in;
      blank_reg <= blank_lz;
    end
  end

  always_comb begin
    msd = '0;
    for (int i = 0; i < N_DIG; i++)
      if (conv_bcd[4*i +: 4] != 4'd0) msd = IW'(i);
    show_minus = neg_reg && (conv_bcd != '0);
    minus_pos  = blank_reg ? int'(msd) + 1 : N_DIG - 1;
    for (int i = 0; i < N_DIG; i++) begin
      fmt[i] = conv_bcd[4*i +: 4];
      if (blank_reg && i > int'(msd)) fmt[i] = DIG_BLANK;
      if (show_minus && i == minus_pos) fmt[i] = DIG_MINUS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_reg <= 1'b0;
      for (int i = 0; i < N_DIG; i++) disp_buf[i] <= DIG_BLANK;
    end else begin
      done_reg <= conv_done;
      if (conv_done)
        for (int i = 0; i < N_DIG; i++) disp_buf[i] <= fmt[i];
    end
  end

  assign tick = (cnt_reg == CNTW'(DIV - 1));

  // an and SSeg are loaded together on each tick so the pins never show a mixed digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      idx_reg <= '0;
      an_reg  <= '1;
      seg_reg <= 7'h7F;
    end else begin
      cnt_reg <= tick ? '0 : cnt_reg + CNTW'(1);
      if (tick) begin
        an_reg  <= ~(N_DIG'(1) << idx_reg);
        seg_reg <= seg_of(disp_buf[idx_reg]);
        idx_reg <= (idx_reg == IW'(N_DIG - 1)) ? '0 : idx_reg + IW'(1);
      end
    end
  end

  assign busy = conv_busy;
  assign done = done_reg;
  assign an   = an_reg;
  assign SSeg = seg_reg;

endmodule

// File: tb/tb_display_num_mux.sv
// Directed bench for display_num_mux with a short refresh divider.
module tb_display_num_mux;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
  localparam logic [6:0] S5 = 7'h12, S7 = 7'h78, S8 = 7'h00;
  localparam logic [6:0] SMI = 7'h3F, SBL = 7'h7F;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] value = 8'd0;
  logic       signed_mode = 1'b0;
  logic       blank_lz = 1'b0;
  logic       busy, done;
  logic [6:0] SSeg;
  logic [3:0] an;

  int total = 0;
  int bad = 0;
  int lat, ndone;
  logic [6:0] cap [4];

  display_num_mux #(.W(8), .N_DIG(4), .DIV(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid       (valid),
    .value       (value),
    .signed_mode (signed_mode),
    .blank_lz    (blank_lz),
    .busy        (busy),
    .done        (done),
    .SSeg        (SSeg),
    .an          (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else
      $display("ok   %s: %0h", tag, got);
  endtask

  // Watch the scan long enough that every digit's last capture is fresh
  task automatic expect_digits(input string tag, input logic [6:0] e3, e2, e1, e0);
    for (int i = 0; i < 4; i++) cap[i] = 7'bx;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      case (an)
        4'b1110: cap[0] = SSeg;
        4'b1101: cap[1] = SSeg;
        4'b1011: cap[2] = SSeg;
        4'b0111: cap[3] = SSeg;
        default: ;
      endcase
    end
    check({tag, " an3"}, {25'd0, cap[3]}, {25'd0, e3});
    check({tag, " an2"}, {25'd0, cap[2]}, {25'd0, e2});
    check({tag, " an1"}, {25'd0, cap[1]}, {25'd0, e1});
    check({tag, " an0"}, {25'd0, cap[0]}, {25'd0, e0});
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic convert(input logic [7:0] v, input logic sm, input logic bl, output int n);
    @(negedge clk);
    valid = 1'b1; value = v; signed_mode = sm; blank_lz = bl;
    @(negedge clk);
    valid = 1'b0;
    wait_done(n);
  endtask

  initial begin
    // 1: reset and the idle scan
    repeat (3) @(negedge clk);
    #1;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst pins", {21'd0, an, SSeg}, {21'd0, 4'hF, 7'h7F});
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("pre-tick pins", {21'd0, an, SSeg}, {21'd0, 4'hF, 7'h7F});
    end
    expect_digits("idle", SBL, SBL, SBL, SBL);

    // 2: 207 unsigned, no blanking
    convert(8'd207, 1'b0, 1'b0, lat);
    check("207 latency", lat, 32'd9);
    @(negedge clk);
    check("done one cycle", {31'd0, done}, 32'd0);
    expect_digits("207", S0, S2, S0, S7);

    // 3: -13 signed, blanking
    convert(8'hF3, 1'b1, 1'b1, lat);
    check("-13 latency", lat, 32'd9);
    expect_digits("-13", SBL, SMI, S1, S3);

    // 4: most negative, then zero in signed mode
    convert(8'h80, 1'b1, 1'b0, lat);
    expect_digits("-128", SMI, S1, S2, S8);
    convert(8'h00, 1'b1, 1'b1, lat);
    expect_digits("zero", SBL, SBL, SBL, S0);

    // 5a: valid while busy is dropped
    @(negedge clk);
    valid = 1'b1; value = 8'd1; signed_mode = 1'b0; blank_lz = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    check("busy after accept", {31'd0, busy}, 32'd1);
    ndone = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin valid = 1'b1; value = 8'd99; end
      if (c == 4) valid = 1'b0;
      @(negedge clk);
      if (done) ndone++;
    end
    check("one done pulse", ndone, 32'd1);
    expect_digits("ignored", SBL, SBL, SBL, S1);

    // 5b: valid presented during the done cycle is accepted
    convert(8'd42, 1'b0, 1'b1, lat);
    valid = 1'b1; value = 8'd5;
    @(negedge clk);
    valid = 1'b0;
    check("busy on done accept", {31'd0, busy}, 32'd1);
    wait_done(lat);
    check("back-to-back latency", lat, 32'd9);
    expect_digits("b2b", SBL, SBL, SBL, S5);

    // 6: reset mid-conversion
    @(negedge clk);
    valid = 1'b1; value = 8'd123; blank_lz = 1'b0;
    @(negedge clk);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async busy", {31'd0, busy}, 32'd0);
    check("async pins", {20'd0, done, an, SSeg}, {20'd0, 1'b0, 4'hF, 7'h7F});
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("no done after abort", ndone, 32'd0);
    expect_digits("aborted", SBL, SBL, SBL, SBL);
    convert(8'd45, 1'b0, 1'b0, lat);
    check("post-reset latency", lat, 32'd9);
    expect_digits("45", S0, S0, S4, S5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
